// File: rtl/control_fsm.sv
// control_fsm: multicycle RV32I control sequencer with memory handshake and retired-instruction counter.
// Optional feature: define CONTROL_FSM_TRAP_EN to trap undefined opcodes in a terminal TRAP state.
module control_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic        alu_ctrl,
    output logic [31:0] instret,
    output logic        illegal
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_ALU_WB, S_JAL, S_JALR,
        S_JALR_PC, S_BRANCH
`ifdef CONTROL_FSM_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t state, next;

    // State register; reset drops any in-flight access back to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next;
    end

    // Retire counter: counts every entry into FETCH from another state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               instret <= '0;
        else if (state != S_FETCH && next == S_FETCH) instret <= instret + 32'd1;
    end

    // Next-state and state-decoded outputs, all forced low while in reset.
    always_comb begin
        next       = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        result_src = 2'd0;
        alu_ctrl   = 1'b0;
        illegal    = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'd2;
                    result_src = 2'd2;
                    ir_we      = mem_ready;
                    pc_we      = mem_ready;
                    next       = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd1;
                    case (opcode)
                        7'b0000011, 7'b0100011: next = S_MEM_ADDR;
                        7'b0110011: next = S_EXEC_R;
                        7'b0010011: next = S_EXEC_I;
                        7'b1101111: next = S_JAL;
                        7'b1100111: next = S_JALR;
                        7'b1100011: next = S_BRANCH;
                        7'b0110111: next = S_LUI;
                        7'b0010111: next = S_AUIPC;
                        7'b1110011: next = S_FETCH;
`ifdef CONTROL_FSM_TRAP_EN
                        default:    next = S_TRAP;
`else
                        default:    next = S_FETCH;
`endif
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd1;
                    next      = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
                end
                S_MEM_READ: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    next    = mem_ready ? S_MEM_WB : S_MEM_READ;
                end
                S_MEM_WB: begin
                    result_src = 2'd1;
                    reg_we     = 1'b1;
                    next       = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    next    = mem_ready ? S_FETCH : S_MEM_WRITE;
                end
                S_EXEC_R: begin
                    alu_src_a = 2'd2;
                    alu_ctrl  = 1'b1;
                    next      = S_ALU_WB;
                end
                S_EXEC_I: begin
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd1;
                    alu_ctrl  = 1'b1;
                    next      = S_ALU_WB;
                end
                S_LUI: begin
                    alu_src_a = 2'd3;
                    alu_src_b = 2'd1;
                    next      = S_ALU_WB;
                end
                S_AUIPC: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd1;
                    next      = S_ALU_WB;
                end
                S_ALU_WB: begin
                    reg_we = 1'b1;
                    next   = S_FETCH;
                end
                S_JAL: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    pc_we     = 1'b1;
                    next      = S_ALU_WB;
                end
                S_JALR: begin
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd1;
                    next      = S_JALR_PC;
                end
                S_JALR_PC: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    pc_we     = 1'b1;
                    next      = S_ALU_WB;
                end
                S_BRANCH: begin
                    pc_we = branch_taken;
                    next  = S_FETCH;
                end
`ifdef CONTROL_FSM_TRAP_EN
                S_TRAP: begin
                    illegal = 1'b1;
                    next    = S_TRAP;
                end
`endif
                default: next = S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: randomized instruction-level check of control_fsm against a per-instruction step model.
module tb_control_fsm;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = '0;
    logic        branch_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, alu_ctrl, illegal;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [31:0] instret;
    logic [13:0] obs;

    int          checks = 0;
    int          errors = 0;
    int unsigned model_ret = 0;
    logic        trapped = 1'b0;
    logic [13:0] q_exp[$];
    logic        q_rdy[$];

    control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
        .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .alu_ctrl(alu_ctrl),
        .instret(instret), .illegal(illegal)
    );

    assign obs = {mem_req, mem_we, adr_src, ir_we, pc_we, reg_we,
                  alu_src_a, alu_src_b, result_src, alu_ctrl, illegal};

    always #5 clk = ~clk;

    function automatic logic [13:0] mk(logic req, logic we, logic adr, logic irw, logic pcw,
                                       logic rw, logic [1:0] a, logic [1:0] b,
                                       logic [1:0] rs, logic ac, logic il);
        return {req, we, adr, irw, pcw, rw, a, b, rs, ac, il};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_vec(input string tag, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s outputs got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic check_ret(input string tag, input logic [31:0] exp);
        checks++;
        assert (instret === exp) else begin
            errors++;
            $error("FAIL %s instret got=%0d exp=%0d", tag, instret, exp);
        end
    endtask

    task automatic push(input logic [13:0] e, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            q_exp.push_back(e);
            q_rdy.push_back(r);
        end
    endtask

    // Expected per-cycle outputs for one instruction, from the instruction class and memory waits.
    task automatic build(input logic [6:0] op, input logic bt, input int wf, input int wm);
        logic [13:0] alu_wb;
        alu_wb = mk(0,0,0,0,0,1,2'd0,2'd0,2'd0,0,0);
        trapped = 1'b0;
        push(mk(1,0,0,0,0,0,2'd0,2'd2,2'd2,0,0), 1'b0, wf);
        push(mk(1,0,0,1,1,0,2'd0,2'd2,2'd2,0,0), 1'b1, 1);
        push(mk(0,0,0,0,0,0,2'd1,2'd1,2'd0,0,0), rnd_bit(), 1);
        case (op)
            7'b0000011: begin
                push(mk(0,0,0,0,0,0,2'd2,2'd1,2'd0,0,0), rnd_bit(), 1);
                push(mk(1,0,1,0,0,0,2'd0,2'd0,2'd0,0,0), 1'b0, wm);
                push(mk(1,0,1,0,0,0,2'd0,2'd0,2'd0,0,0), 1'b1, 1);
                push(mk(0,0,0,0,0,1,2'd0,2'd0,2'd1,0,0), rnd_bit(), 1);
            end
            7'b0100011: begin
                push(mk(0,0,0,0,0,0,2'd2,2'd1,2'd0,0,0), rnd_bit(), 1);
                push(mk(1,1,1,0,0,0,2'd0,2'd0,2'd0,0,0), 1'b0, wm);
                push(mk(1,1,1,0,0,0,2'd0,2'd0,2'd0,0,0), 1'b1, 1);
            end
            7'b0110011: begin
                push(mk(0,0,0,0,0,0,2'd2,2'd0,2'd0,1,0), rnd_bit(), 1);
                push(alu_wb, rnd_bit(), 1);
            end
            7'b0010011: begin
                push(mk(0,0,0,0,0,0,2'd2,2'd1,2'd0,1,0), rnd_bit(), 1);
                push(alu_wb, rnd_bit(), 1);
            end
            7'b0110111: begin
                push(mk(0,0,0,0,0,0,2'd3,2'd1,2'd0,0,0), rnd_bit(), 1);
                push(alu_wb, rnd_bit(), 1);
            end
            7'b0010111: begin
                push(mk(0,0,0,0,0,0,2'd1,2'd1,2'd0,0,0), rnd_bit(), 1);
                push(alu_wb, rnd_bit(), 1);
            end
            7'b1101111: begin
                push(mk(0,0,0,0,1,0,2'd1,2'd2,2'd0,0,0), rnd_bit(), 1);
                push(alu_wb, rnd_bit(), 1);
            end
            7'b1100111: begin
                push(mk(0,0,0,0,0,0,2'd2,2'd1,2'd0,0,0), rnd_bit(), 1);
                push(mk(0,0,0,0,1,0,2'd1,2'd2,2'd0,0,0), rnd_bit(), 1);
                push(alu_wb, rnd_bit(), 1);
            end
            7'b1100011: push(mk(0,0,0,0,bt,0,2'd0,2'd0,2'd0,0,0), rnd_bit(), 1);
            7'b1110011: ;
            default: begin
`ifdef CONTROL_FSM_TRAP_EN
                trapped = 1'b1;
                push(mk(0,0,0,0,0,0,2'd0,2'd0,2'd0,0,1), rnd_bit(), 10);
`endif
            end
        endcase
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n && q_exp.size() > 0; i++) begin
            mem_ready = q_rdy.pop_front();
            #1 check_vec(tag, obs, q_exp.pop_front());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input string tag, input logic [6:0] op, input logic bt,
                             input int wf, input int wm);
        opcode = op;
        branch_taken = bt;
        check_ret({tag, "_start"}, model_ret);
        build(op, bt, wf, wm);
        drain(tag, 1000);
        if (!trapped) model_ret++;
    endtask

    logic [6:0] ops[14] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                            7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1110011,
                            7'b0000000, 7'b1111111, 7'b0001111, 7'b0010011};

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = 7'b0010011;
        repeat (3) @(posedge clk);
        #1 check_vec("reset_hold", obs, '0);
        check_ret("reset_hold", 32'd0);
        rst_n = 1'b1;
        run_instr("addi", 7'b0010011, 1'b0, 0, 0);
        run_instr("lw_wait3", 7'b0000011, 1'b0, 0, 3);
        run_instr("beq_nt", 7'b1100011, 1'b0, 0, 0);
        run_instr("beq_t", 7'b1100011, 1'b1, 0, 0);
        run_instr("jalr", 7'b1100111, 1'b0, 0, 0);
        run_instr("jal", 7'b1101111, 1'b0, 1, 0);
        run_instr("sw_wait2", 7'b0100011, 1'b0, 2, 2);
        run_instr("lui", 7'b0110111, 1'b0, 0, 0);
        run_instr("auipc", 7'b0010111, 1'b0, 0, 0);
        run_instr("add", 7'b0110011, 1'b0, 0, 0);
        run_instr("system", 7'b1110011, 1'b0, 0, 0);
`ifndef CONTROL_FSM_TRAP_EN
        run_instr("undef_nop", 7'b0000000, 1'b0, 0, 0);
        for (int i = 0; i < 200; i++)
            run_instr("rand", ops[$urandom_range(0, 13)], rnd_bit(),
                      $urandom_range(0, 2), $urandom_range(0, 3));
`else
        for (int i = 0; i < 200; i++)
            run_instr("rand", ops[$urandom_range(0, 9)], rnd_bit(),
                      $urandom_range(0, 2), $urandom_range(0, 3));
`endif
        check_ret("after_rand", model_ret);
        opcode = 7'b0000011;
        build(7'b0000011, 1'b0, 0, 5);
        drain("lw_abort", 5);
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1 check_vec("abort_reset", obs, '0);
        check_ret("abort_reset", 32'd0);
        @(posedge clk);
        #1 check_vec("abort_reset_hold", obs, '0);
        q_exp.delete();
        q_rdy.delete();
        model_ret = 0;
        rst_n = 1'b1;
        run_instr("addi_after_abort", 7'b0010011, 1'b0, 0, 0);
        check_ret("end_count", model_ret);
`ifdef CONTROL_FSM_TRAP_EN
        run_instr("trap", 7'b0000000, 1'b0, 0, 0);
        check_ret("trap_count", model_ret);
        rst_n = 1'b0;
        #1 check_vec("trap_reset", obs, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_ret = 0;
        run_instr("addi_after_trap", 7'b0010011, 1'b0, 0, 0);
        check_ret("trap_recovered", model_ret);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle control unit for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects, the register/PC/IR write strobes and the `aluCtrl` input of the decoder. It also runs the request/ready handshake to unified instruction/data memory and keeps a retired-instruction counter.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `opcode` in 7: `IR[6:0]`, valid from DECODE onward.
- `branch_taken` in 1: comparator result for the current BRANCH, combinational from register data.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request.
- `mem_we` out 1: store when high, load when low.
- `adr_src` out 1: memory address select. 0 = PC, 1 = ALU_OUT register.
- `ir_we` out 1: IR and OLD_PC write enable.
- `pc_we` out 1: PC write enable. The PC loads the `result_src` mux.
- `reg_we` out 1: register-file write enable.
- `alu_src_a` out 2: 0 = PC, 1 = OLD_PC, 2 = RS1, 3 = ZERO.
- `alu_src_b` out 2: 0 = RS2, 1 = IMM, 2 = constant 4.
- `result_src` out 2: 0 = ALU_OUT (registered), 1 = MEM_DATA, 2 = ALU_RESULT (combinational).
- `alu_ctrl` out 1: decoder `aluCtrl`. 0 = ADD_OP, 1 = ALU_OP.
- `instret` out 32: count of retired instructions.
- `illegal` out 1: trap flag. Only with `CONTROL_FSM_TRAP_EN`; otherwise tied 0.

## Operation
- Outputs are combinational from state. Strobes marked "on ready" also qualify with `mem_ready`.
- Any output not listed for a state is 0.
- **FETCH**: `mem_req`=1, `adr_src`=0, `alu_src_a`=0, `alu_src_b`=2, `result_src`=2.
  - On ready: `ir_we`=`pc_we`=1, go to DECODE.
  - Otherwise: stay in FETCH.
- **DECODE**: `alu_src_a`=1, `alu_src_b`=1 (branch/JAL target into ALU_OUT). Next state by opcode:
  - 0000011 or 0100011 → MEM_ADDR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1101111 → JAL
  - 1100111 → JALR
  - 1100011 → BRANCH
  - 0110111 → LUI
  - 0010111 → AUIPC
  - 1110011 (SYSTEM) → FETCH, treated as NOP
  - any other opcode → ILLEGAL handling (see Configuration)
- **MEM_ADDR**: `alu_src_a`=2, `alu_src_b`=1. Go to MEM_READ if `opcode[5]`=0, else MEM_WRITE.
- **MEM_READ**: `mem_req`=1, `adr_src`=1. On ready go to MEM_WB.
- **MEM_WB**: `result_src`=1, `reg_we`=1. Go to FETCH.
- **MEM_WRITE**: `mem_req`=`mem_we`=1, `adr_src`=1. On ready go to FETCH.
- **EXEC_R**: `alu_src_a`=2, `alu_src_b`=0, `alu_ctrl`=1. Go to ALU_WB.
- **EXEC_I**: `alu_src_a`=2, `alu_src_b`=1, `alu_ctrl`=1. Go to ALU_WB.
- **LUI**: `alu_src_a`=3, `alu_src_b`=1. Go to ALU_WB.
- **AUIPC**: `alu_src_a`=1, `alu_src_b`=1. Go to ALU_WB.
- **ALU_WB**: `result_src`=0, `reg_we`=1. Go to FETCH.
- **JAL**: `alu_src_a`=1, `alu_src_b`=2, `result_src`=0, `pc_we`=1. Go to ALU_WB.
- **JALR**: `alu_src_a`=2, `alu_src_b`=1. Go to JALR_PC.
- **JALR_PC**: `result_src`=0, `pc_we`=1, `alu_src_a`=1, `alu_src_b`=2. Go to ALU_WB.
- **BRANCH**: `result_src`=0, `pc_we`=`branch_taken`. Go to FETCH.
- `instret` increments by 1 on every transition into FETCH except out of reset. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset:
  - While `rst_n`=0: state=FETCH, `instret`=0, `illegal`=0, and every output is forced to 0, including `mem_req`.
  - First cycle after release: FETCH with `mem_req`=1.
- Handshake:
  - `mem_req`, `mem_we` and `adr_src` stay stable until the cycle `mem_ready`=1 is sampled.
  - A transfer completes on the rising edge where `mem_req`=`mem_ready`=1.
  - `mem_ready` is ignored while `mem_req`=0.
  - `mem_ready` already high in the first request cycle gives a 1-cycle access.
- Reset mid-request abandons the access immediately. No retry; `instret` is not incremented.
- Cycle counts with zero-wait memory:
  - ALU, LUI, AUIPC: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 4
  - JALR: 5
  - SYSTEM: 2
  - Each memory wait cycle adds 1.

## Configuration
- `CONTROL_FSM_TRAP_EN` defined:
  - An undefined opcode in DECODE enters TRAP. In TRAP, `illegal`=1 and all strobes are 0.
  - TRAP is terminal until `rst_n` is asserted.
  - `instret` does not count the trapping instruction.
- Macro undefined:
  - An undefined opcode behaves as SYSTEM: NOP, 2 cycles, counted in `instret`.
  - No TRAP state exists; `illegal` is constant 0.

## Test plan
- Reset: hold `rst_n`=0 with `mem_ready`=1 → all outputs 0 and `instret`=0. Release → next cycle `mem_req`=1, `adr_src`=0.
- ADDI (opcode 0010011), `mem_ready`=1 always → FETCH, DECODE, EXEC_I (`alu_ctrl`=1), ALU_WB (`reg_we`=1). 4 cycles; `instret` 0→1.
- LW with `mem_ready` low for 3 cycles in MEM_READ → `mem_req`/`adr_src`=1 held for 4 cycles. `reg_we`=1 with `result_src`=1 in cycle 8.
- BEQ (1100011) with `branch_taken`=0 → no `pc_we` in BRANCH; FETCH in cycle 4. Repeat with `branch_taken`=1 → `pc_we`=1, `result_src`=0 in cycle 3.
- JALR → `pc_we` in cycle 4 (JALR_PC); `reg_we` in cycle 5; next FETCH in cycle 6.
- Opcode 0000000 → with macro: `illegal`=1 persists and `mem_req` stays 0 for 10 cycles. Without macro: FETCH in cycle 3 and `instret` increments.
